// File: rtl/mgt_01_mul_unit.sv
// Radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Multiplies operand magnitudes over 32 cycles, then sign-corrects the product in one more cycle.

package Modules_pkg;
    localparam int XLEN = 32;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;
endpackage

package Instruction_pkg;
    typedef enum logic [1:0] {
        MUL_    = 2'd0,
        MULH_   = 2'd1,
        MULHSU_ = 2'd2,
        MULHU_  = 2'd3
    } mul_ops_e;
endpackage

module mgt_01_mul_unit
    import Modules_pkg::*;
    import Instruction_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            clk_en_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] multiplicand_i,
    input  logic [XLEN-1:0] multiplier_i,
    input  mul_ops_e        operation_i,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o,
    output fu_state_e       fu_state_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULTIPLY = 2'd1,
        FIX_SIGN = 2'd2
    } state_e;

    state_e            r_state;
    state_e            w_next;
    logic [4:0]        r_count;
    mul_ops_e          r_op;
    logic              r_sign_a;
    logic              r_sign_b;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_a;
    logic [XLEN:0]     r_p;

    logic              w_sign_a;
    logic              w_sign_b;
    logic [XLEN-1:0]   w_abs_b;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_fixed;

    always_comb begin
        w_sign_a = (operation_i != MULHU_) && multiplicand_i[XLEN-1];
        w_sign_b = ((operation_i == MUL_) || (operation_i == MULH_)) && multiplier_i[XLEN-1];
        // Negating 0x80000000 wraps to itself, which is the correct unsigned magnitude.
        w_abs_b  = w_sign_a ? (~multiplicand_i + 1'b1) : multiplicand_i;
        w_abs_a  = w_sign_b ? (~multiplier_i + 1'b1) : multiplier_i;
        w_sum    = r_p + {1'b0, (r_a[0] ? r_b : {XLEN{1'b0}})};
        w_prod   = {r_p[XLEN-1:0], r_a};
        w_fixed  = (r_sign_a ^ r_sign_b) ? (~w_prod + 1'b1) : w_prod;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (valid_i) w_next = MULTIPLY;
            MULTIPLY: if (r_count == 5'd31) w_next = FIX_SIGN;
            FIX_SIGN: w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else if (clk_en_i) begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_count  <= '0;
            r_op     <= MUL_;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b      <= '0;
            r_a      <= '0;
            r_p      <= '0;
            result_o <= '0;
            valid_o  <= 1'b0;
        end else if (clk_en_i) begin
            case (r_state)
                IDLE: begin
                    valid_o <= 1'b0;
                    if (valid_i) begin
                        r_op     <= operation_i;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_b      <= w_abs_b;
                        r_a      <= w_abs_a;
                        r_p      <= '0;
                        r_count  <= '0;
                    end
                end
                MULTIPLY: begin
                    r_p     <= {1'b0, w_sum[XLEN:1]};
                    r_a     <= {w_sum[0], r_a[XLEN-1:1]};
                    r_count <= r_count + 5'd1;
                end
                FIX_SIGN: begin
                    result_o <= (r_op == MUL_) ? w_fixed[XLEN-1:0] : w_fixed[2*XLEN-1:XLEN];
                    valid_o  <= 1'b1;
                end
                default: valid_o <= 1'b0;
            endcase
        end
    end

    always_comb begin
        fu_state_o = (r_state == IDLE) ? FREE : BUSY;
    end

endmodule

// File: tb/tb_mgt_01_mul_unit.sv
// Self-checking bench for mgt_01_mul_unit: directed corner cases plus random operations
// compared against a plain 64-bit arithmetic reference model.

module tb_mgt_01_mul_unit;
    import Modules_pkg::*;
    import Instruction_pkg::*;

    logic        clk;
    logic        rstN;
    logic        clkEn;
    logic        validIn;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    mul_ops_e    operation;
    logic [31:0] result;
    logic        validOut;
    fu_state_e   fuState;

    int          checks;
    int          errors;
    logic [31:0] expectedResult;

    mgt_01_mul_unit dut (
        .clk_i          (clk),
        .rst_n_i        (rstN),
        .clk_en_i       (clkEn),
        .valid_i        (validIn),
        .multiplicand_i (multiplicand),
        .multiplier_i   (multiplier),
        .operation_i    (operation),
        .result_o       (result),
        .valid_o        (validOut),
        .fu_state_o     (fuState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: extend each operand per the op's signedness and take the 64-bit product.
    function automatic logic [31:0] refModel(input mul_ops_e op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == MULHU_) ? {32'd0, a} : {{32{a[31]}}, a};
        eb = (op == MUL_ || op == MULH_) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (op == MUL_) ? p[31:0] : p[63:32];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accept edge with inputs scrambled.
    task automatic applyStimulus(input mul_ops_e op, input logic [31:0] a, input logic [31:0] b);
        validIn      = 1'b1;
        multiplicand = a;
        multiplier   = b;
        operation    = op;
        @(negedge clk);
        validIn      = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        operation    = mul_ops_e'(2'($urandom_range(0, 3)));
        expectedResult = refModel(op, a, b);
    endtask

    task automatic waitResult(input string tag, input int elapsed, input int expLatency);
        int  n;
        bit  seen;
        n    = elapsed;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            @(negedge clk);
            n++;
            if (validOut === 1'b1) seen = 1'b1;
        end
        checkOutput({tag, "_latency"}, 64'(n), 64'(expLatency));
        checkOutput({tag, "_result"}, {32'd0, result}, {32'd0, expectedResult});
    endtask

    task automatic runDirected(input string tag, input mul_ops_e op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expLit);
        applyStimulus(op, a, b);
        expectedResult = expLit;
        waitResult(tag, 0, 33);
        @(negedge clk);
        checkOutput({tag, "_pulse_end"}, {63'd0, validOut}, 64'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rstN         = 1'b0;
        clkEn        = 1'b1;
        validIn      = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        operation    = MUL_;
        repeat (3) @(negedge clk);
        checkOutput("reset_result", {32'd0, result}, 64'd0);
        checkOutput("reset_valid", {63'd0, validOut}, 64'd0);
        checkOutput("reset_state", {63'd0, fuState}, {63'd0, FREE});
        rstN = 1'b1;
        @(negedge clk);

        // Basic MUL with busy/free tracking around the whole operation.
        applyStimulus(MUL_, 32'd7, 32'd6);
        expectedResult = 32'h0000002A;
        checkOutput("mul7x6_busy", {63'd0, fuState}, {63'd0, BUSY});
        waitResult("mul7x6", 0, 33);
        checkOutput("mul7x6_free", {63'd0, fuState}, {63'd0, FREE});
        @(negedge clk);
        checkOutput("mul7x6_pulse_end", {63'd0, validOut}, 64'd0);

        runDirected("mulh_m3x5",     MULH_,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF);
        runDirected("mul_m3x5",      MUL_,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1);
        runDirected("mulh_min_min",  MULH_,   32'h80000000, 32'h80000000, 32'h40000000);
        runDirected("mul_min_min",   MUL_,    32'h80000000, 32'h80000000, 32'h00000000);
        runDirected("mulhsu_ff",     MULHSU_, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        runDirected("mulhu_ff",      MULHU_,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        runDirected("mul_ff",        MUL_,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);

        // A start request while busy must be ignored.
        applyStimulus(MUL_, 32'd7, 32'd6);
        repeat (4) @(negedge clk);
        validIn      = 1'b1;
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        operation    = MUL_;
        @(negedge clk);
        validIn = 1'b0;
        waitResult("busy_ignore", 5, 33);

        // Back-to-back: new request in the valid_o cycle.
        applyStimulus(MUL_, 32'd2, 32'd3);
        checkOutput("b2b_valid_drop", {63'd0, validOut}, 64'd0);
        waitResult("b2b", 0, 33);

        // Clock enable low for 5 cycles mid-multiply, then held during the pulse.
        applyStimulus(MULH_, 32'h89ABCDEF, 32'h76543210);
        repeat (10) @(negedge clk);
        clkEn = 1'b0;
        repeat (5) @(negedge clk);
        clkEn = 1'b1;
        waitResult("clken_stall", 15, 38);
        clkEn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("clken_pulse_hold", {63'd0, validOut}, 64'd1);
        checkOutput("clken_result_hold", {32'd0, result}, {32'd0, expectedResult});
        clkEn = 1'b1;
        @(negedge clk);
        checkOutput("clken_pulse_end", {63'd0, validOut}, 64'd0);

        // Asynchronous reset mid-operation clears outputs without a clock edge.
        applyStimulus(MULHU_, 32'hDEADBEEF, 32'h12345678);
        repeat (10) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checkOutput("abort_result", {32'd0, result}, 64'd0);
        checkOutput("abort_valid", {63'd0, validOut}, 64'd0);
        checkOutput("abort_state", {63'd0, fuState}, {63'd0, FREE});
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        runDirected("restart_zero", MUL_, 32'd0, 32'h12345678, 32'h00000000);

        // Random operations against the reference model.
        for (int i = 0; i < 16; i++) begin
            mul_ops_e    op;
            logic [31:0] a;
            logic [31:0] b;
            op = mul_ops_e'(2'($urandom_range(0, 3)));
            a  = $urandom;
            b  = $urandom;
            if (i % 4 == 1) a = 32'h80000000;
            if (i % 4 == 2) b = 32'hFFFFFFFF;
            applyStimulus(op, a, b);
            waitResult($sformatf("rand%0d_op%0d", i, op), 0, 33);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
